// File: rtl/tail_light_decoder_pkg.sv
// Shared types and lamp-pattern constants for the tail-light decoder.
// Pattern bit order is {la,lb,lc,ra,rb,rc}; lamp A is the innermost lamp.
package tail_light_pkg;

    typedef enum logic [2:0] {
        S_OFF = 3'd0,
        S_L1  = 3'd1,
        S_L2  = 3'd2,
        S_L3  = 3'd3,
        S_R1  = 3'd4,
        S_R2  = 3'd5,
        S_R3  = 3'd6,
        S_HAZ = 3'd7
    } tld_state_e;

    localparam logic [5:0] PAT_OFF = 6'b000_000;
    localparam logic [5:0] PAT_L1  = 6'b100_000;
    localparam logic [5:0] PAT_L2  = 6'b110_000;
    localparam logic [5:0] PAT_L3  = 6'b111_000;
    localparam logic [5:0] PAT_R1  = 6'b000_100;
    localparam logic [5:0] PAT_R2  = 6'b000_110;
    localparam logic [5:0] PAT_R3  = 6'b000_111;
    localparam logic [5:0] PAT_HAZ = 6'b111_111;

    // Lamp pattern that a state represents; seeing it again means "hold".
    function automatic logic [5:0] state_pattern(tld_state_e s);
        case (s)
            S_L1:    return PAT_L1;
            S_L2:    return PAT_L2;
            S_L3:    return PAT_L3;
            S_R1:    return PAT_R1;
            S_R2:    return PAT_R2;
            S_R3:    return PAT_R3;
            S_HAZ:   return PAT_HAZ;
            default: return PAT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/tail_light_decoder_if.sv
// Lamp inputs and decoded status of the tail-light decoder.
// Handshake: none -- the lamps are a free-running level bus sampled every
// rising edge; status outputs are valid one cycle after the sampled pattern.
// master = lamp driver / observer side, slave = decoder side.
interface tail_light_decoder_if #(parameter int CNT_W = 8);
    import tail_light_pkg::*;

    logic             la, lb, lc, ra, rb, rc;
    logic             left_act;
    logic             right_act;
    logic             haz_act;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] left_cnt;
    logic [CNT_W-1:0] right_cnt;
    logic [CNT_W-1:0] haz_cnt;
    tld_state_e       state_dbg;

    modport master (
        output la, lb, lc, ra, rb, rc,
        input  left_act, right_act, haz_act, err, err_sticky,
        input  left_cnt, right_cnt, haz_cnt, state_dbg
    );

    modport slave (
        input  la, lb, lc, ra, rb, rc,
        output left_act, right_act, haz_act, err, err_sticky,
        output left_cnt, right_cnt, haz_cnt, state_dbg
    );

endinterface

// File: rtl/tail_light_decoder_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones.
module tld_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Increment on enable unless already saturated; synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tail_light_decoder.sv
// Tail-light decoder: tracks the six-lamp turn-signal pattern, recovers the
// active command, flags illegal patterns/transitions.
// Optional macro TLD_STATS_EN enables the completed-cycle counters; when it
// is undefined the counter outputs are constant zero and no counter flops exist.
module tail_light_decoder
    import tail_light_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    tail_light_decoder_if.slave bus
);

    logic [5:0] pat;
    tld_state_e state_q, state_d;
    logic       illegal;
    logic       done_l, done_r, done_h;
    logic       err_q, err_sticky_q;
    logic       left_q, right_q, haz_q;

    assign pat = {bus.la, bus.lb, bus.lc, bus.ra, bus.rb, bus.rc};

    // State register plus registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_OFF;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            haz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= illegal;
            err_sticky_q <= err_sticky_q | illegal;
            left_q       <= (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
            right_q      <= (state_d == S_R1) || (state_d == S_R2) || (state_d == S_R3);
            haz_q        <= (state_d == S_HAZ);
        end
    end

    // Next-state: hold on own pattern, advance on the next legal pattern,
    // anything else is an error that resyncs to S_OFF.
    always_comb begin
        state_d = S_OFF;
        illegal = 1'b0;
        done_l  = 1'b0;
        done_r  = 1'b0;
        done_h  = 1'b0;
        if (pat == state_pattern(state_q)) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (pat == PAT_L1)       state_d = S_L1;
                    else if (pat == PAT_R1)  state_d = S_R1;
                    else if (pat == PAT_HAZ) state_d = S_HAZ;
                    else                     illegal = 1'b1;
                end
                S_L1: begin
                    if (pat == PAT_L2)       state_d = S_L2;
                    else if (pat != PAT_OFF) illegal = 1'b1;
                end
                S_L2: begin
                    if (pat == PAT_L3)       state_d = S_L3;
                    else if (pat != PAT_OFF) illegal = 1'b1;
                end
                S_R1: begin
                    if (pat == PAT_R2)       state_d = S_R2;
                    else if (pat != PAT_OFF) illegal = 1'b1;
                end
                S_R2: begin
                    if (pat == PAT_R3)       state_d = S_R3;
                    else if (pat != PAT_OFF) illegal = 1'b1;
                end
                S_L3: begin
                    if (pat == PAT_OFF) done_l  = 1'b1;
                    else                illegal = 1'b1;
                end
                S_R3: begin
                    if (pat == PAT_OFF) done_r  = 1'b1;
                    else                illegal = 1'b1;
                end
                S_HAZ: begin
                    if (pat == PAT_OFF) done_h  = 1'b1;
                    else                illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign bus.left_act   = left_q;
    assign bus.right_act  = right_q;
    assign bus.haz_act    = haz_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.state_dbg  = state_q;

`ifdef TLD_STATS_EN
    tld_sat_counter #(.W(CNT_W)) u_left_cnt (
        .clk(clk), .reset(reset), .en(done_l), .count(bus.left_cnt)
    );
    tld_sat_counter #(.W(CNT_W)) u_right_cnt (
        .clk(clk), .reset(reset), .en(done_r), .count(bus.right_cnt)
    );
    tld_sat_counter #(.W(CNT_W)) u_haz_cnt (
        .clk(clk), .reset(reset), .en(done_h), .count(bus.haz_cnt)
    );
`else
    // Completion strobes have no consumer without statistics.
    logic unused_done;
    assign unused_done   = done_l ^ done_r ^ done_h;
    assign bus.left_cnt  = {CNT_W{1'b0}};
    assign bus.right_cnt = {CNT_W{1'b0}};
    assign bus.haz_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_tail_light_decoder.sv
// Directed bench for tail_light_decoder: a CNT_W=8 instance for the main
// scenarios and a CNT_W=2 instance for counter saturation, both fed the same
// lamp pattern.
module tb_tail_light_decoder;
    import tail_light_pkg::*;

`ifdef TLD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic exp_q[$];

    tail_light_decoder_if #(.CNT_W(8)) tli ();
    tail_light_decoder_if #(.CNT_W(2)) tls ();

    tail_light_decoder #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(tli.slave));
    tail_light_decoder #(.CNT_W(2)) dut_small (.clk(clk), .reset(reset), .bus(tls.slave));

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a pattern mid-cycle, let one rising edge sample it, settle 1 time unit.
    task automatic drive(input logic [5:0] p);
        @(negedge clk);
        {tli.la, tli.lb, tli.lc, tli.ra, tli.rb, tli.rc} = p;
        {tls.la, tls.lb, tls.lc, tls.ra, tls.rb, tls.rc} = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(PAT_OFF);
        drive(PAT_OFF);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({tli.left_act, tli.right_act, tli.haz_act, tli.err, tli.err_sticky} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {tli.left_act, tli.right_act, tli.haz_act, tli.err, tli.err_sticky});
        end
        n_tests++;
        if ({tli.left_cnt, tli.right_cnt, tli.haz_cnt} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0", {tli.left_cnt, tli.right_cnt, tli.haz_cnt});
        end
        n_tests++;
        if (tli.state_dbg !== S_OFF) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", tli.state_dbg, S_OFF);
        end
    endtask

    task automatic test_left();
        logic [5:0] seq[5];
        logic       e;
        seq = '{PAT_OFF, PAT_L1, PAT_L2, PAT_L3, PAT_OFF};
        do_reset();
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (tli.left_act !== e || tli.err !== 1'b0) begin
                n_fail++;
                $display("FAIL left_step%0d: left_act=%b err=%b want left_act=%b err=0",
                         i, tli.left_act, tli.err, e);
            end
        end
        n_tests++;
        if (tli.left_cnt !== (STATS ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL left_cnt: got %0d want %0d", tli.left_cnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_right_held();
        logic [5:0] seq[7];
        seq = '{PAT_R1, PAT_R1, PAT_R2, PAT_R2, PAT_R3, PAT_R3, PAT_OFF};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(seq[i]);
            n_tests++;
            if (tli.right_act !== (i < 6) || tli.left_act !== 1'b0 || tli.err !== 1'b0) begin
                n_fail++;
                $display("FAIL right_step%0d: right_act=%b left_act=%b err=%b want right_act=%b",
                         i, tli.right_act, tli.left_act, tli.err, i < 6);
            end
        end
        n_tests++;
        if (tli.right_cnt !== (STATS ? 8'd1 : 8'd0) || tli.left_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL right_cnt: right=%0d left=%0d want right=%0d left=0",
                     tli.right_cnt, tli.left_cnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                drive(PAT_HAZ);
                n_tests++;
                if (tli.haz_act !== 1'b1 || tli.err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL haz_on r%0d k%0d: haz_act=%b err=%b want 1,0", r, k, tli.haz_act, tli.err);
                end
            end
            drive(PAT_OFF);
            n_tests++;
            if (tli.haz_act !== 1'b0) begin
                n_fail++;
                $display("FAIL haz_off r%0d: haz_act=%b want 0", r, tli.haz_act);
            end
        end
        n_tests++;
        if (tli.haz_cnt !== (STATS ? 8'd4 : 8'd0) || tli.err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL haz_cnt: got %0d sticky=%b want %0d sticky=0",
                     tli.haz_cnt, tli.err_sticky, STATS ? 4 : 0);
        end
    endtask

    task automatic test_skip_step();
        do_reset();
        drive(PAT_L1);
        drive(PAT_L3);
        n_tests++;
        if (tli.err !== 1'b1 || tli.err_sticky !== 1'b1 || tli.left_act !== 1'b0 ||
            tli.state_dbg !== S_OFF) begin
            n_fail++;
            $display("FAIL skip_err: err=%b sticky=%b left_act=%b state=%0d want 1,1,0,0",
                     tli.err, tli.err_sticky, tli.left_act, tli.state_dbg);
        end
        drive(PAT_L1);
        n_tests++;
        if (tli.err !== 1'b0 || tli.left_act !== 1'b1 || tli.err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL skip_resync: err=%b left_act=%b sticky=%b want 0,1,1",
                     tli.err, tli.left_act, tli.err_sticky);
        end
    endtask

    task automatic test_back_to_back_err();
        do_reset();
        drive(PAT_L2);
        n_tests++;
        if (tli.err !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_err1: err=%b want 1", tli.err);
        end
        drive(6'b100_100);
        n_tests++;
        if (tli.err !== 1'b1 || tli.err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_err2: err=%b sticky=%b want 1,1", tli.err, tli.err_sticky);
        end
        drive(PAT_OFF);
        n_tests++;
        if (tli.err !== 1'b0 || tli.err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold: err=%b sticky=%b want 0,1", tli.err, tli.err_sticky);
        end
        do_reset();
        #1;
        n_tests++;
        if (tli.err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_clear: sticky=%b want 0", tli.err_sticky);
        end
    endtask

    task automatic test_illegal_misc();
        // backward step L2 -> L1
        do_reset();
        drive(PAT_L1);
        drive(PAT_L2);
        drive(PAT_L1);
        n_tests++;
        if (tli.err !== 1'b1 || tli.left_act !== 1'b0) begin
            n_fail++;
            $display("FAIL backward: err=%b left_act=%b want 1,0", tli.err, tli.left_act);
        end
        // hazard entry mid right sequence
        do_reset();
        drive(PAT_R1);
        drive(PAT_HAZ);
        n_tests++;
        if (tli.err !== 1'b1 || tli.haz_act !== 1'b0 || tli.right_act !== 1'b0) begin
            n_fail++;
            $display("FAIL haz_mid: err=%b haz_act=%b right_act=%b want 1,0,0",
                     tli.err, tli.haz_act, tli.right_act);
        end
        // legal abort from R2: no err, no count
        do_reset();
        drive(PAT_R1);
        drive(PAT_R2);
        drive(PAT_OFF);
        n_tests++;
        if (tli.err !== 1'b0 || tli.err_sticky !== 1'b0 || tli.right_cnt !== 8'd0 ||
            tli.right_act !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: err=%b sticky=%b cnt=%0d act=%b want 0,0,0,0",
                     tli.err, tli.err_sticky, tli.right_cnt, tli.right_act);
        end
        // reset mid-sequence: no count, no err
        drive(PAT_L1);
        drive(PAT_L2);
        drive(PAT_L3);
        do_reset();
        drive(PAT_OFF);
        n_tests++;
        if (tli.err !== 1'b0 || tli.left_cnt !== 8'd0 || tli.left_act !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: err=%b cnt=%0d act=%b want 0,0,0",
                     tli.err, tli.left_cnt, tli.left_act);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(PAT_L1);
            drive(PAT_L2);
            drive(PAT_L3);
            drive(PAT_OFF);
            if (c == 1) begin
                n_tests++;
                if (tls.left_cnt !== (STATS ? 2'd2 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL sat_mid: got %0d want %0d", tls.left_cnt, STATS ? 2 : 0);
                end
            end
        end
        n_tests++;
        if (tls.left_cnt !== (STATS ? 2'd3 : 2'd0) || tls.err !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_final: got %0d err=%b want %0d err=0",
                     tls.left_cnt, tls.err, STATS ? 3 : 0);
        end
        n_tests++;
        if (tli.left_cnt !== (STATS ? 8'd5 : 8'd0)) begin
            n_fail++;
            $display("FAIL wide_cnt5: got %0d want %0d", tli.left_cnt, STATS ? 5 : 0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        {tli.la, tli.lb, tli.lc, tli.ra, tli.rb, tli.rc} = PAT_OFF;
        {tls.la, tls.lb, tls.lc, tls.ra, tls.rb, tls.rc} = PAT_OFF;
        test_reset();
        test_left();
        test_right_held();
        test_hazard();
        test_skip_step();
        test_back_to_back_err();
        test_illegal_misc();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
